// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared op codes, sequencer states and constants for the MIPS mul/div unit.
package mips_cpu_muldiv_pkg;

    localparam int unsigned MD_ITER   = 32;
    localparam logic [31:0] MD_DBZ_LO = 32'hFFFFFFFF;

    // The signed-divide op is MD_DIVS because MD_DIV is taken by the state enum.
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIVS  = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_e;

endpackage

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: 32-step shift-add
// or restoring divide on magnitudes, then a single sign-fix/write-back cycle.
module mips_cpu_muldiv_unit
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = MD_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(ITER);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic               sign_p_q, sign_p_d;
    logic               sign_r_q, sign_r_d;
    logic               is_div_q, is_div_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    md_op_e             op_e;
    logic               signed_op, neg_a, neg_b, op_is_div;
    logic [WIDTH:0]     rem_sh, div_ext;
    logic               qbit;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rem;

    assign op_e = md_op_e'(op);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        araw_d     = araw_q;
        sign_p_d   = sign_p_q;
        sign_r_d   = sign_r_q;
        is_div_d   = is_div_q;
        dbz_flag_d = dbz_flag_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        signed_op  = 1'b0;
        neg_a      = 1'b0;
        neg_b      = 1'b0;
        op_is_div  = 1'b0;
        rem_sh     = '0;
        div_ext    = '0;
        qbit       = 1'b0;
        product    = '0;
        quot       = '0;
        rem        = '0;

        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op_e)
                        MD_MULT, MD_MULTU, MD_DIVS, MD_DIVU: begin
                            signed_op  = (op_e == MD_MULT) || (op_e == MD_DIVS);
                            op_is_div  = (op_e == MD_DIVS) || (op_e == MD_DIVU);
                            neg_a      = signed_op && a[WIDTH-1];
                            neg_b      = signed_op && b[WIDTH-1];
                            opa_d      = {{WIDTH{1'b0}}, (neg_a ? -a : a)};
                            opb_d      = neg_b ? -b : b;
                            araw_d     = a;
                            sign_p_d   = neg_a ^ neg_b;
                            sign_r_d   = neg_a;
                            is_div_d   = op_is_div;
                            dbz_flag_d = op_is_div && (b == '0);
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = op_is_div ? MD_DIV : MD_MUL;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end

            MD_MUL: begin
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = MD_FIX;
            end

            MD_DIV: begin
                // acc holds {remainder, quotient}; dividend bits stream in from opa MSB.
                rem_sh  = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
                div_ext = {1'b0, opb_q};
                if (rem_sh >= div_ext) begin
                    rem_sh = rem_sh - div_ext;
                    qbit   = 1'b1;
                end
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], qbit};
                opa_d = opa_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = MD_FIX;
            end

            MD_FIX: begin
                if (is_div_q) begin
                    quot = sign_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    rem  = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    if (dbz_flag_q) begin
                        hi_d = araw_q;
                        lo_d = WIDTH'(MD_DBZ_LO);
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    dbz_d = dbz_flag_q;
                end else begin
                    product = sign_p_q ? -acc_q : acc_q;
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end

            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            araw_q     <= '0;
            sign_p_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            is_div_q   <= 1'b0;
            dbz_flag_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            araw_q     <= araw_d;
            sign_p_q   <= sign_p_d;
            sign_r_q   <= sign_r_d;
            is_div_q   <= is_div_d;
            dbz_flag_q <= dbz_flag_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != MD_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed-vector bench for mips_cpu_muldiv_unit: result values, 34-edge latency,
// HI/LO hold while busy, MTHI/MTLO, ignored start while busy and mid-op reset.
module tb_mips_cpu_muldiv_unit;
    import mips_cpu_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Accepts one op, optionally injects a start while busy, and waits (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input int inject_at, output int n, output logic hold_ok);
        logic [W-1:0] hi0, lo0;
        @(posedge clk); #1;
        hi0 = hi; lo0 = lo;
        op = o; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib;
        n = 1; hold_ok = 1'b1;
        check("busy_after_accept", busy, 1);
        while (!done && n < 100) begin
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            if (n == inject_at) begin
                $display("note: start issued while busy (protocol violation, must be ignored)");
                start = 1'b1; op = MD_MTHI; a = 32'hDEADBEEF; b = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int inject_at);
        int   n;
        logic hold_ok;
        run_op(v.op, v.a, v.b, inject_at, n, hold_ok);
        check({v.name, "_latency"}, n, 34);
        check({v.name, "_done"}, done, 1);
        check({v.name, "_busy_at_done"}, busy, 0);
        check({v.name, "_hi"}, hi, v.hi);
        check({v.name, "_lo"}, lo, v.lo);
        check({v.name, "_dbz"}, div_by_zero, v.dbz);
        check({v.name, "_hold"}, hold_ok, 1);
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, {done, div_by_zero}, 2'b00);
    endtask

    initial begin
        vecs[0]  = '{"multu_max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{"mult_neg3x5", MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{"mult_minsq",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{"div_neg7d2",  MD_DIVS,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{"divu_100d7",  MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[5]  = '{"divu_dbz",    MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{"div_ovf",     MD_DIVS,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{"div_7dneg2",  MD_DIVS,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{"mult_m1m1",   MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[9]  = '{"div_dbz_s",   MD_DIVS,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{"multu_3x4",   MD_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0};

        #12;
        check("reset_outputs", {busy, done, div_by_zero}, 3'b000);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], -1);

        // MTHI/MTLO single-cycle writes; last vector left hi=0, lo=C.
        @(posedge clk); #1;
        op = MD_MTHI; a = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo_kept", lo, 32'h0000000C);
        check("mthi_flags", {busy, done}, 2'b00);
        op = MD_MTLO; a = 32'hCAFEF00D; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'h12345678);
        op = 3'b110; a = 32'h55555555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("undef_op", {busy, done, hi, lo}, {2'b00, 32'h12345678, 32'hCAFEF00D});

        // Start issued at cycle 5 of a DIVU must not disturb it.
        run_vec(vecs[4], 5);

        // Reset asserted mid-divide clears everything immediately.
        @(posedge clk); #1;
        op = MD_DIVU; a = 32'h00001000; b = 32'h00000003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_hilo", {hi, lo}, 64'h0);
        check("midreset_done", {done, div_by_zero}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(vecs[10], -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
